od_serial_tx: RTL and testbench
===============================

Name: od_serial_tx

Overview:
Open-drain serial frame transmitter for a wired-AND single-line bus. The line idles high through a pull-up. This block only ever pulls the line low or releases it. Its drive_low output is the gate enable for the pad's nmos pull-down to supply0; there is no pmos drive. The block reads the line back to detect collisions and lost arbitration against other open-drain drivers on the same net.

Parameters:
DATA_WIDTH, 8, payload bits per frame; sent MSB first.
BIT_CYCLES, 4, clk cycles per bit time; legal range 4..255, minimum set by synchronizer latency.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
tx_data  input  DATA_WIDTH  payload; captured on accept.
tx_valid  input  1  request to send tx_data.
tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready.
line_in  input  1  raw bus level from the pad, asynchronous to clk.
drive_low  output  1  registered; 1 = pull line low, 0 = release.
busy  output  1  high from accept until return to IDLE.
done  output  1  one-cycle pulse when a frame completes without collision.
arb_lost  output  1  one-cycle pulse when a collision aborts a frame.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, drive_low=0, busy=0, done=0, arb_lost=0, tx_ready=1.
  - Both synchronizer flops are set to 1 (idle-high).
  - Mid-frame reset releases the line immediately, without waiting for a clock edge.
- line_in passes through a 2-flop synchronizer; line_s is its output, 2-cycle latency.
- Frame: start bit (low), then DATA_WIDTH data bits MSB first (0 = low, 1 = released), then stop bit (released).
- Every bit lasts exactly BIT_CYCLES cycles. bit_cnt counts 0..BIT_CYCLES-1 within each bit.
- States:
  - IDLE:
    - tx_ready=1.
    - On accept: latch tx_data into the shift register, busy<=1, go to WAIT_BUS.
  - WAIT_BUS:
    - Wait while line_s=0 (bus occupied).
    - First cycle line_s=1: go to START with drive_low<=1 and bit_cnt<=0.
  - START:
    - drive_low=1 for BIT_CYCLES cycles.
    - Then go to DATA; drive_low<=~shift[MSB].
  - DATA:
    - Each bit is held BIT_CYCLES cycles.
    - At bit_cnt==BIT_CYCLES-1, sample line_s: released bit (1) sampled as 0 means arbitration lost.
    - Otherwise shift left and load the next bit.
    - After bit DATA_WIDTH-1, go to STOP with drive_low<=0.
  - STOP:
    - Released for BIT_CYCLES cycles, with the same check at the last cycle.
    - Pass: done<=1, busy<=0, go to IDLE.
- Arbitration loss / collision, from DATA or STOP:
  - On the next edge: arb_lost<=1, drive_low<=0, busy<=0, state<=IDLE.
  - The frame is abandoned; there is no retry.
- Driven-low bits are never checked.
- done and arb_lost are mutually exclusive and last exactly one cycle. tx_ready rises in the same cycle as the pulse.
- tx_valid while busy is ignored. tx_data is don't-care except at accept.
- Frame occupancy from START entry to done: (DATA_WIDTH+2)*BIT_CYCLES cycles.
- A bit counter of ceil(log2(DATA_WIDTH)) bits tracks the data index. All counters wrap only by explicit reload; there is no free-running wrap.

Decomposition:
- Package od_bus_pkg:
  - state enum: IDLE, WAIT_BUS, START, DATA, STOP.
  - constants: LINE_IDLE=1'b1, LINE_ACTIVE=1'b0.
- One sub-module, sync_2ff: generic 2-flop synchronizer.
  - Async active-low reset, reset value 1.
  - Instanced for line_in.

Test Plan:
- Bench setup: DATA_WIDTH=8, BIT_CYCLES=4, line_in = ~(drive_low | ext_low).
- Reset mid-DATA -> drive_low=0 with no clock edge; after reset release, tx_ready=1, busy=0, no done or arb_lost pulse.
- Send 0xA5, ext_low=0 -> drive_low sequence (4 cycles each) 1 | 0,1,0,1,1,0,1,0 | 0. done pulses once, 40 cycles after START entry; arb_lost never asserts.
- ext_low=1 for 20 cycles, then send 0x3C accepted during it -> state stays WAIT_BUS and drive_low=0 throughout. START begins 3 cycles after ext_low falls (2 synchronizer cycles plus 1 registering cycle); frame otherwise correct.
- Send 0xFF, ext_low=1 during data bit 2 -> arb_lost pulses at the edge after that bit's last cycle, drive_low=0 from then on, no done, tx_ready=1.
- Send 0x00, ext_low=1 during the stop bit -> arb_lost pulse, no done.
- tx_valid held high with 0x00 then 0x01 -> second frame accepted the cycle tx_ready returns after done; 0x01 shows a single released bit in the last data slot. A tx_valid toggle while busy causes no extra accept.

Source files
------------

// File: rtl/od_bus_pkg.sv
// rtl/od_bus_pkg.sv - shared types and line constants for the open-drain serial transmitter
package od_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUS = 3'd1,
        START    = 3'd2,
        DATA     = 3'd3,
        STOP     = 3'd4
    } od_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic LINE_ACTIVE = 1'b0;

    // Width of the per-bit cycle counter; covers the full 4..255 bit-time range.
    localparam int CNT_W = 8;

    // A released bit that reads back low means another driver owns the bus.
    function automatic logic released_bit_overridden(input logic drive_low, input logic line_s);
        return (drive_low == 1'b0) && (line_s == LINE_ACTIVE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with configurable reset level
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/od_serial_tx.sv
// rtl/od_serial_tx.sv - open-drain frame transmitter with bus-busy wait and arbitration-loss detection
module od_serial_tx
    import od_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  line_in,
    output logic                  drive_low,
    output logic                  busy,
    output logic                  done,
    output logic                  arb_lost
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    od_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_drive_low;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_arb_lost;

    od_state_t             w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0]      w_bit_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_drive_low_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_arb_lost_nxt;
    logic                  w_line_s;
    logic                  w_bit_last;

    sync_2ff #(
        .RST_VAL (LINE_IDLE)
    ) u_line_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (line_in),
        .o_q     (w_line_s)
    );

    // drive_low sits on the async reset so a mid-frame reset frees the bus at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_idx       <= '0;
            r_drive_low <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_arb_lost  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_drive_low <= w_drive_low_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_arb_lost  <= w_arb_lost_nxt;
        end
    end

    assign w_bit_last = (r_bit_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_idx_nxt       = r_idx;
        w_drive_low_nxt = r_drive_low;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_arb_lost_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_shift_nxt = tx_data;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = WAIT_BUS;
                end
            end

            WAIT_BUS: begin
                if (w_line_s == LINE_IDLE) begin
                    w_state_nxt     = START;
                    w_drive_low_nxt = 1'b1;
                    w_bit_cnt_nxt   = '0;
                end
            end

            START: begin
                if (w_bit_last) begin
                    w_state_nxt     = DATA;
                    w_drive_low_nxt = ~r_shift[DATA_WIDTH-1];
                    w_bit_cnt_nxt   = '0;
                    w_idx_nxt       = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end

            DATA: begin
                if (w_bit_last) begin
                    w_bit_cnt_nxt = '0;
                    if (released_bit_overridden(r_drive_low, w_line_s)) begin
                        w_state_nxt     = IDLE;
                        w_drive_low_nxt = 1'b0;
                        w_busy_nxt      = 1'b0;
                        w_arb_lost_nxt  = 1'b1;
                    end else if (r_idx == IDX_LAST) begin
                        w_state_nxt     = STOP;
                        w_drive_low_nxt = 1'b0;
                    end else begin
                        w_shift_nxt     = {r_shift[DATA_WIDTH-2:0], 1'b0};
                        w_drive_low_nxt = ~r_shift[DATA_WIDTH-2];
                        w_idx_nxt       = r_idx + 1'b1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end

            STOP: begin
                if (w_bit_last) begin
                    w_bit_cnt_nxt   = '0;
                    w_state_nxt     = IDLE;
                    w_drive_low_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                    if (w_line_s == LINE_ACTIVE) begin
                        w_arb_lost_nxt = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_drive_low_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    always_comb begin
        tx_ready  = (r_state == IDLE);
        drive_low = r_drive_low;
        busy      = r_busy;
        done      = r_done;
        arb_lost  = r_arb_lost;
    end

endmodule

// File: tb/tb_od_serial_tx.sv
// tb/tb_od_serial_tx.sv - directed self-checking bench for od_serial_tx on a wired-AND line
module tb_od_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       drive_low;
    logic       busy;
    logic       done;
    logic       arb_lost;
    logic       ext_low;
    logic       line_in;

    int n_pass  = 0;
    int n_total = 0;

    assign line_in = ~(drive_low | ext_low);

    od_serial_tx #(
        .DATA_WIDTH (8),
        .BIT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .line_in   (line_in),
        .drive_low (drive_low),
        .busy      (busy),
        .done      (done),
        .arb_lost  (arb_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic accept(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic capture_frame(input int max_wait, output int waited,
                                 output logic [39:0] pat, output logic pulse_seen);
        waited = 0;
        while (drive_low !== 1'b1 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        pat        = '0;
        pulse_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pat[39-i] = drive_low;
            if (done !== 1'b0 || arb_lost !== 1'b0) pulse_seen = 1'b1;
            if (i < 39) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ext_low  = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (drive_low !== 1'b0) $display("FAIL reset_drive_low: got %b want 0", drive_low); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (arb_lost !== 1'b0) $display("FAIL reset_arb_lost: got %b want 0", arb_lost); else n_pass++;
        n_total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else n_pass++;
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_midframe_reset();
        logic bad;
        accept(8'h00);
        repeat (8) @(negedge clk);
        n_total++; if (drive_low !== 1'b1) $display("FAIL mid_reset_pre_drive: got %b want 1", drive_low); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if (drive_low !== 1'b0) $display("FAIL mid_reset_async_release: got %b want 0", drive_low); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || arb_lost !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1 || drive_low !== 1'b0) bad = 1'b1;
        end
        n_total++; if (bad !== 1'b0) $display("FAIL mid_reset_quiet_after: got %b want 0", bad); else n_pass++;
    endtask

    task automatic test_frame_a5();
        int          waited;
        logic [39:0] pat;
        logic        pulse;
        accept(8'hA5);
        n_total++; if (busy !== 1'b1) $display("FAIL a5_busy_after_accept: got %b want 1", busy); else n_pass++;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL a5_ready_after_accept: got %b want 0", tx_ready); else n_pass++;
        capture_frame(10, waited, pat, pulse);
        n_total++; if (waited !== 1) $display("FAIL a5_start_latency: got %0d want 1", waited); else n_pass++;
        n_total++; if (pat !== 40'hF0F0FF0F00) $display("FAIL a5_pattern: got %h want f0f0ff0f00", pat); else n_pass++;
        n_total++; if (pulse !== 1'b0) $display("FAIL a5_early_pulse: got %b want 0", pulse); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b1) $display("FAIL a5_done: got %b want 1", done); else n_pass++;
        n_total++; if (arb_lost !== 1'b0) $display("FAIL a5_arb_lost: got %b want 0", arb_lost); else n_pass++;
        n_total++; if (tx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL a5_ready_busy_at_done: got %b%b want 10", tx_ready, busy); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL a5_done_one_cycle: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_wait_bus();
        int          waited;
        logic [39:0] pat;
        logic        pulse;
        logic        held_ok;
        @(negedge clk);
        ext_low = 1'b1;
        repeat (4) @(negedge clk);
        accept(8'h3C);
        held_ok = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (drive_low !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) held_ok = 1'b0;
            @(negedge clk);
        end
        n_total++; if (held_ok !== 1'b1) $display("FAIL wait_bus_hold: got %b want 1", held_ok); else n_pass++;
        @(negedge clk);
        ext_low = 1'b0;
        capture_frame(10, waited, pat, pulse);
        n_total++; if (waited !== 3) $display("FAIL wait_bus_start_latency: got %0d want 3", waited); else n_pass++;
        n_total++; if (pat !== 40'hFFF0000FF0) $display("FAIL wait_bus_pattern: got %h want fff0000ff0", pat); else n_pass++;
        n_total++; if (pulse !== 1'b0) $display("FAIL wait_bus_early_pulse: got %b want 0", pulse); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b1 || arb_lost !== 1'b0) $display("FAIL wait_bus_done: got done=%b arb=%b want 1 0", done, arb_lost); else n_pass++;
    endtask

    task automatic test_arb_data();
        int   waited;
        logic early;
        logic bad;
        accept(8'hFF);
        waited = 0;
        while (drive_low !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_total++; if (waited !== 1) $display("FAIL arb_data_start_latency: got %0d want 1", waited); else n_pass++;
        repeat (12) @(negedge clk);
        n_total++; if (drive_low !== 1'b0) $display("FAIL arb_data_bit2_released: got %b want 0", drive_low); else n_pass++;
        ext_low = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0 || arb_lost !== 1'b0) early = 1'b1;
            if (i < 3) @(negedge clk);
        end
        n_total++; if (early !== 1'b0) $display("FAIL arb_data_early_pulse: got %b want 0", early); else n_pass++;
        @(negedge clk);
        n_total++; if (arb_lost !== 1'b1) $display("FAIL arb_data_arb_lost: got %b want 1", arb_lost); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL arb_data_no_done: got %b want 0", done); else n_pass++;
        n_total++; if (tx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL arb_data_ready_busy: got %b%b want 10", tx_ready, busy); else n_pass++;
        ext_low = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || arb_lost !== 1'b0 || drive_low !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_total++; if (bad !== 1'b0) $display("FAIL arb_data_abandoned: got %b want 0", bad); else n_pass++;
    endtask

    task automatic test_arb_stop();
        int   waited;
        logic early;
        accept(8'h00);
        waited = 0;
        while (drive_low !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        repeat (36) @(negedge clk);
        n_total++; if (drive_low !== 1'b0) $display("FAIL arb_stop_released: got %b want 0", drive_low); else n_pass++;
        ext_low = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || arb_lost !== 1'b0) early = 1'b1;
        end
        n_total++; if (early !== 1'b0) $display("FAIL arb_stop_early_pulse: got %b want 0", early); else n_pass++;
        @(negedge clk);
        n_total++; if (arb_lost !== 1'b1 || done !== 1'b0) $display("FAIL arb_stop_pulse: got arb=%b done=%b want 1 0", arb_lost, done); else n_pass++;
        n_total++; if (tx_ready !== 1'b1) $display("FAIL arb_stop_ready: got %b want 1", tx_ready); else n_pass++;
        ext_low = 1'b0;
        @(negedge clk);
        n_total++; if (arb_lost !== 1'b0 || done !== 1'b0) $display("FAIL arb_stop_one_cycle: got arb=%b done=%b want 0 0", arb_lost, done); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          waited;
        logic [39:0] pat;
        logic        pulse;
        logic        bad;
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h01;
        waited  = 0;
        while (drive_low !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        pat   = '0;
        pulse = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pat[39-i] = drive_low;
            if (done !== 1'b0 || arb_lost !== 1'b0) pulse = 1'b1;
            if (i == 10) tx_valid = 1'b0;
            if (i == 12) tx_valid = 1'b1;
            if (i < 39) @(negedge clk);
        end
        n_total++; if (pat !== 40'hFFFFFFFFF0) $display("FAIL b2b_first_pattern: got %h want fffffffff0", pat); else n_pass++;
        n_total++; if (pulse !== 1'b0) $display("FAIL b2b_first_early_pulse: got %b want 0", pulse); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b1 || tx_ready !== 1'b1) $display("FAIL b2b_first_done: got done=%b ready=%b want 1 1", done, tx_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b1 || tx_ready !== 1'b0) $display("FAIL b2b_second_accept: got busy=%b ready=%b want 1 0", busy, tx_ready); else n_pass++;
        tx_valid = 1'b0;
        capture_frame(10, waited, pat, pulse);
        n_total++; if (waited !== 1) $display("FAIL b2b_second_latency: got %0d want 1", waited); else n_pass++;
        n_total++; if (pat !== 40'hFFFFFFFF00) $display("FAIL b2b_second_pattern: got %h want ffffffff00", pat); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b1 || arb_lost !== 1'b0) $display("FAIL b2b_second_done: got done=%b arb=%b want 1 0", done, arb_lost); else n_pass++;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_ready !== 1'b1 || drive_low !== 1'b0) bad = 1'b1;
        end
        n_total++; if (bad !== 1'b0) $display("FAIL b2b_no_extra_accept: got %b want 0", bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_midframe_reset();
        test_frame_a5();
        test_wait_bus();
        test_arb_data();
        test_arb_stop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
